// File: rtl/axi_delay_sched.sv
// Per-channel AXI handshake stall scheduler: each channel holds its gate closed for a
// programmed fixed or LFSR-masked random number of cycles before every beat may complete.
module axi_delay_sched #(
  parameter int          DelayWidth  = 8,
  parameter int          ResetDelay  = 1,
  parameter bit          ResetRandom = 1'b0,
  parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4:0]            valid_i,
  input  logic [4:0]            ready_i,
  output logic [4:0]            gate_o,
  input  logic                  cfg_we_i,
  input  logic [2:0]            cfg_chan_i,
  input  logic                  cfg_en_i,
  input  logic                  cfg_random_i,
  input  logic [DelayWidth-1:0] cfg_delay_i,
  output logic [4:0]            busy_o
);

  localparam int NumChan = 5;

  typedef enum logic [1:0] {IDLE, WAIT, OPEN} state_e;

  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11, free-running every cycle
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  for (genvar gi = 0; gi < NumChan; gi++) begin : g_chan
    localparam int Rot = 3 * gi;

    state_e                state_q, state_d;
    logic [DelayWidth-1:0] cnt_q, cnt_d;
    logic                  sh_en_q, sh_en_d, sh_rnd_q, sh_rnd_d;
    logic [DelayWidth-1:0] sh_dly_q, sh_dly_d;
    logic                  act_en_q, act_en_d, act_rnd_q, act_rnd_d;
    logic [DelayWidth-1:0] act_dly_q, act_dly_d;
    logic                  we_hit;
    logic [DelayWidth-1:0] rnd_dly, load_val;

    assign we_hit   = cfg_we_i && (cfg_chan_i == 3'(gi));
    // Each channel taps a differently rotated LFSR so channels stall uncorrelated
    assign rnd_dly  = DelayWidth'((lfsr_q << Rot) | (lfsr_q >> (16 - Rot))) & act_dly_q;
    assign load_val = act_rnd_q ? rnd_dly : act_dly_q;

    always_comb begin
      sh_en_d   = we_hit ? cfg_en_i     : sh_en_q;
      sh_rnd_d  = we_hit ? cfg_random_i : sh_rnd_q;
      sh_dly_d  = we_hit ? cfg_delay_i  : sh_dly_q;
      act_en_d  = act_en_q;
      act_rnd_d = act_rnd_q;
      act_dly_d = act_dly_q;
      // Active copy only follows the shadow between beats, never mid-beat
      if (state_q == IDLE) begin
        act_en_d  = sh_en_d;
        act_rnd_d = sh_rnd_d;
        act_dly_d = sh_dly_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        IDLE: begin
          if (valid_i[gi] && act_en_q) begin
            cnt_d   = load_val;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (!valid_i[gi]) begin
            state_d = IDLE;
          end else if (cnt_q == '0) begin
            state_d = OPEN;
          end else begin
            cnt_d = cnt_q - DelayWidth'(1);
          end
        end
        OPEN: begin
          if (!valid_i[gi] || ready_i[gi]) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
      if (!act_en_q) begin
        state_d = IDLE;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        sh_en_q   <= 1'b1;
        sh_rnd_q  <= ResetRandom;
        sh_dly_q  <= DelayWidth'(ResetDelay);
        act_en_q  <= 1'b1;
        act_rnd_q <= ResetRandom;
        act_dly_q <= DelayWidth'(ResetDelay);
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        sh_en_q   <= sh_en_d;
        sh_rnd_q  <= sh_rnd_d;
        sh_dly_q  <= sh_dly_d;
        act_en_q  <= act_en_d;
        act_rnd_q <= act_rnd_d;
        act_dly_q <= act_dly_d;
      end
    end

    // Bypass opens the gate straight from the active enable, independent of valid/ready
    assign gate_o[gi] = ~act_en_q | (state_q == OPEN);
    assign busy_o[gi] = (state_q != IDLE);
  end

endmodule

// File: tb/tb_axi_delay_sched.sv
// Scoreboard bench for axi_delay_sched: stimulus queues per-cycle expected gate/busy
// values, a negedge monitor pops and compares them against the DUT.
module tb_axi_delay_sched;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [4:0] valid_i = '0;
  logic [4:0] ready_i = '0;
  logic [4:0] gate_o;
  logic       cfg_we_i = 1'b0;
  logic [2:0] cfg_chan_i = '0;
  logic       cfg_en_i = 1'b0;
  logic       cfg_random_i = 1'b0;
  logic [7:0] cfg_delay_i = '0;
  logic [4:0] busy_o;

  axi_delay_sched dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_i     (ready_i),
    .gate_o      (gate_o),
    .cfg_we_i    (cfg_we_i),
    .cfg_chan_i  (cfg_chan_i),
    .cfg_en_i    (cfg_en_i),
    .cfg_random_i(cfg_random_i),
    .cfg_delay_i (cfg_delay_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int    cyc;
    int    ch;
    logic  g;
    logic  b;
    string nm;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] lfsr_m = 16'hACE1;
  logic        rnd_on = 1'b0;
  logic        do_final = 1'b0;
  logic        final_done = 1'b0;
  logic        busy3_prev = 1'b0;
  logic        gate3_prev = 1'b0;
  int          w_start = 0;
  logic [7:0]  cov = '0;
  int          bad_wait = 0;
  int          rnd_seen = 0;

  localparam int NumBeats = 1000;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (rst_i) lfsr_m <= 16'hACE1;
    else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  always @(negedge clk_i) begin
    exp_t e;
    int   w;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_vec++;
      if (e.cyc != cyc || gate_o[e.ch] !== e.g || busy_o[e.ch] !== e.b) begin
        n_err++;
        $display("FAIL %s cyc=%0d ch=%0d: got gate=%b busy=%b, want gate=%b busy=%b (due cyc %0d)",
                 e.nm, cyc, e.ch, gate_o[e.ch], busy_o[e.ch], e.g, e.b, e.cyc);
      end
    end
    if (rnd_on) begin
      if (busy_o[3] && !busy3_prev) w_start = cyc;
      if (gate_o[3] && !gate3_prev) begin
        w = cyc - w_start + 1;
        rnd_seen++;
        if (w >= 2 && w <= 9) cov[w-2] = 1'b1;
        else bad_wait++;
      end
    end
    busy3_prev = busy_o[3];
    gate3_prev = gate_o[3];
    if (do_final && !final_done) begin
      final_done = 1'b1;
      n_vec += 4;
      if (sb.size() != 0) begin
        n_err++;
        $display("FAIL sb_drain: got %0d pending entries, want 0", sb.size());
      end
      if (cov != 8'hFF) begin
        n_err++;
        $display("FAIL rnd_cover: got wait-value mask %h, want ff", cov);
      end
      if (bad_wait != 0) begin
        n_err++;
        $display("FAIL rnd_range: got %0d waits outside 2..9, want 0", bad_wait);
      end
      if (rnd_seen != NumBeats) begin
        n_err++;
        $display("FAIL rnd_beats: got %0d gate openings, want %0d", rnd_seen, NumBeats);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input string nm, input int c, input int ch, input logic g, input logic b);
    exp_t e;
    e.cyc = c; e.ch = ch; e.g = g; e.b = b; e.nm = nm;
    sb.push_back(e);
  endtask

  // Drive one channel for n cycles from bit patterns (bit k = cycle k), optionally
  // inserting a config write at cycle wk and a reset pulse at cycle rk.
  task automatic phase(input string nm, input int ch, input int n,
                       input logic [31:0] v, input logic [31:0] r,
                       input logic [31:0] g, input logic [31:0] b,
                       input int wk, input int wch, input logic wen, input logic wrnd,
                       input logic [7:0] wd, input int rk);
    int base;
    base = cyc;
    for (int k = 0; k < n; k++) push(nm, base + k, ch, g[k], b[k]);
    for (int k = 0; k < n; k++) begin
      valid_i[ch]  = v[k];
      ready_i[ch]  = r[k];
      rst_i        = (k == rk);
      cfg_we_i     = (k == wk);
      cfg_chan_i   = 3'(wch);
      cfg_en_i     = wen;
      cfg_random_i = wrnd;
      cfg_delay_i  = wd;
      tick();
    end
    valid_i  = '0;
    ready_i  = '0;
    rst_i    = 1'b0;
    cfg_we_i = 1'b0;
    repeat (3) tick();
  endtask

  function automatic int rnd_delay(input logic [15:0] l);
    logic [15:0] rr;
    rr = (l << 9) | (l >> 7);
    return int'(rr[7:0] & 8'h07);
  endfunction

  initial begin
    int t;
    int d;
    rst_i = 1'b1;
    tick();
    tick();
    for (int c = 0; c < 5; c++) push("reset", cyc, c, 1'b0, 1'b0);

    // AW fixed D=1, valid/ready held: open at 3, close at 4, open at 7
    phase("aw_d1", 0, 9, 32'h0FF, 32'h0FF, 32'h088, 32'h0EE, -1, 0, 0, 0, 0, -1);

    // R fixed D=0, ready only at cycle 10
    phase("r_cfg", 4, 2, 0, 0, 0, 0, 0, 4, 1, 0, 8'd0, -1);
    phase("r_d0", 4, 12, 32'h7FF, 32'h400, 32'h7FC, 32'h7FE, -1, 0, 0, 0, 0, -1);

    // AR bypass, then restore scheduling with D=0
    phase("ar_bypass", 2, 6, 32'h1A, 32'h08, 32'h3E, 32'h00, 0, 2, 0, 0, 8'd0, -1);
    phase("ar_restore", 2, 5, 32'h0E, 32'h08, 32'h09, 32'h0C, 0, 2, 1, 0, 8'd0, -1);

    // W D=20, rewritten to D=0 mid-wait: this beat waits 20, the next waits 0
    phase("w_cfg20", 1, 2, 0, 0, 0, 0, 0, 1, 1, 0, 8'd20, -1);
    phase("w_midcfg", 1, 28, 32'h077F_FFFF, 32'h0440_0000, 32'h0440_0000, 32'h067F_FFFE,
          5, 1, 1, 0, 8'd0, -1);

    // Valid dropped during WAIT on AW (D=1)
    phase("aw_vdrop", 0, 4, 32'h03, 32'h00, 32'h00, 32'h06, -1, 0, 0, 0, 0, -1);

    // Reset during OPEN on R, colliding with a bypass write that must be ignored
    phase("r_rst", 4, 6, 32'h3F, 32'h00, 32'h0C, 32'h2E, 3, 4, 0, 0, 8'd0, 3);

    // Write to nonexistent channel 6 must leave every channel scheduling
    phase("cfg_ch6", 0, 2, 0, 0, 0, 0, 0, 6, 0, 0, 8'd0, -1);
    for (int c = 1; c < 5; c++) phase("cfg_ch6", c, 2, 0, 0, 0, 0, -1, 0, 0, 0, 0, -1);

    // B random mode, mask 7, back-to-back beats
    phase("b_cfgrnd", 3, 2, 0, 0, 0, 0, 0, 3, 1, 1, 8'h07, -1);
    rnd_on     = 1'b1;
    valid_i[3] = 1'b1;
    ready_i[3] = 1'b1;
    for (int i = 0; i < NumBeats; i++) begin
      t = cyc;
      d = rnd_delay(lfsr_m);
      push("b_rnd", t, 3, 1'b0, 1'b0);
      for (int k = 1; k <= d + 1; k++) push("b_rnd", t + k, 3, 1'b0, 1'b1);
      push("b_rnd", t + d + 2, 3, 1'b1, 1'b1);
      repeat (d + 3) tick();
    end
    valid_i[3] = 1'b0;
    ready_i[3] = 1'b0;
    tick();
    rnd_on = 1'b0;
    repeat (3) tick();

    do_final = 1'b1;
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
